// File: rtl/scc_pkg.sv
// Shared definitions for the single-cycle computer's stack engine:
// state encoding, fault codes, SP register slot and word size.
package scc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2,
        FLT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_TIMEOUT = 2'd0,
        FC_OVF     = 2'd1,
        FC_UNF     = 2'd2,
        FC_ALIGN   = 2'd3
    } fault_code_t;

    localparam int          SP_IDX     = 4;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/stack_engine_if.sv
// Bundle of op-request, SP register-file and data-memory signals around the
// stack engine. master = control/regfile/memory side, slave = the engine.
interface stack_engine_if;
    import scc_pkg::*;

    logic        op_valid;
    logic        op_ready;
    logic        op_push;
    logic [31:0] push_data;
    logic [31:0] sp_in;
    logic        wr_sp;
    logic [31:0] wr_sp_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic        fault;
    fault_code_t fault_code;
    logic [31:0] pop_data;

    modport master (
        output op_valid, op_push, push_data, sp_in, mem_rdata, mem_ack,
        input  op_ready, wr_sp, wr_sp_data, mem_req, mem_we, mem_addr,
               mem_wdata, done, fault, fault_code, pop_data
    );

    modport slave (
        input  op_valid, op_push, push_data, sp_in, mem_rdata, mem_ack,
        output op_ready, wr_sp, wr_sp_data, mem_req, mem_we, mem_addr,
               mem_wdata, done, fault, fault_code, pop_data
    );

endinterface

// File: rtl/stack_engine.sv
// Multi-cycle push/pop sequencer: validates SP, performs one memory word
// access over req/ack, then writes the updated SP back to the register file.
module stack_engine
    import scc_pkg::*;
#(
    parameter logic [31:0] STACK_BASE  = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0800,
    parameter int          TIMEOUT     = 16
) (
    input  logic         clk,
    input  logic         reset,
    stack_engine_if.slave bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [31:0]      new_sp;

    logic             acc_bad;
    fault_code_t      acc_code;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_sp;

    // Priority: alignment/range first, then full on push, then empty on pop.
    function automatic logic [2:0] check_sp(input logic [31:0] sp, input logic push);
        if (sp[1:0] != 2'b00 || sp < STACK_LIMIT || sp > STACK_BASE)
            return {1'b1, FC_ALIGN};
        else if (push && sp == STACK_LIMIT)
            return {1'b1, FC_OVF};
        else if (!push && sp == STACK_BASE)
            return {1'b1, FC_UNF};
        else
            return {1'b0, FC_TIMEOUT};
    endfunction

    always_comb begin
        logic [2:0] chk;
        chk      = check_sp(bus.sp_in, bus.op_push);
        acc_bad  = chk[2];
        acc_code = fault_code_t'(chk[1:0]);
        // Full-descending stack: push pre-decrements, pop post-increments.
        acc_addr = bus.op_push ? (bus.sp_in - WORD_BYTES) : bus.sp_in;
        acc_sp   = bus.op_push ? (bus.sp_in - WORD_BYTES) : (bus.sp_in + WORD_BYTES);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bus.op_ready   <= 1'b1;
            bus.wr_sp      <= 1'b0;
            bus.wr_sp_data <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.done       <= 1'b0;
            bus.fault      <= 1'b0;
            bus.fault_code <= FC_TIMEOUT;
            bus.pop_data   <= '0;
            tmo_cnt        <= '0;
            new_sp         <= '0;
        end else begin
            // Completion strobes are single-cycle unless re-asserted below.
            bus.wr_sp <= 1'b0;
            bus.done  <= 1'b0;
            bus.fault <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.op_valid) begin
                        bus.op_ready <= 1'b0;
                        if (acc_bad) begin
                            state          <= FLT;
                            bus.done       <= 1'b1;
                            bus.fault      <= 1'b1;
                            bus.fault_code <= acc_code;
                        end else begin
                            state         <= MEM;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.op_push;
                            bus.mem_addr  <= acc_addr;
                            bus.mem_wdata <= bus.push_data;
                            new_sp        <= acc_sp;
                            tmo_cnt       <= '0;
                        end
                    end
                end

                MEM: begin
                    // An ack on the last allowed cycle still completes the op.
                    if (bus.mem_ack) begin
                        state          <= WB;
                        bus.mem_req    <= 1'b0;
                        bus.wr_sp      <= 1'b1;
                        bus.wr_sp_data <= new_sp;
                        bus.done       <= 1'b1;
                        if (!bus.mem_we)
                            bus.pop_data <= bus.mem_rdata;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state          <= FLT;
                        bus.mem_req    <= 1'b0;
                        bus.done       <= 1'b1;
                        bus.fault      <= 1'b1;
                        bus.fault_code <= FC_TIMEOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                WB, FLT: begin
                    state        <= IDLE;
                    bus.op_ready <= 1'b1;
                end

                default: begin
                    state        <= IDLE;
                    bus.op_ready <= 1'b1;
                    bus.mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Multi-cycle push/pop sequencer that owns stack-pointer updates for the single-cycle computer.
- Reads the current SP from the special-register file (SP slot, index 4). Performs one word access to data memory over a req/ack handshake. Then writes the updated SP back through the special-register file's dedicated SP write port (wr_sp / wr_sp_data).
- Sits between the decode/control stage (issues ops) and the special-register file plus data memory.

Parameters:
- STACK_BASE, 32'h0000_1000, address one word above the highest stack slot; SP value when the stack is empty.
- STACK_LIMIT, 32'h0000_0800, lowest legal SP; SP value when the stack is full.
- TIMEOUT, 16, maximum cycles mem_req may wait for mem_ack before the op is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  op request from control.
- op_ready  out  1  engine idle and able to accept an op.
- op_push  in  1  1 = push, 0 = pop; sampled with op_valid.
- push_data  in  32  word to push; sampled at accept.
- sp_in  in  32  current SP, driven from the register-file SP read port.
- wr_sp  out  1  one-cycle SP write enable to the register file.
- wr_sp_data  out  32  new SP value.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = store (push), 0 = load (pop).
- mem_addr  out  32  word address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data; valid when mem_ack = 1.
- mem_ack  in  1  memory completion strobe.
- done  out  1  one-cycle completion pulse (success or fault).
- fault  out  1  qualifies done; 1 = op aborted.
- fault_code  out  2  0 = timeout, 1 = overflow, 2 = underflow, 3 = misaligned/out-of-range SP.
- pop_data  out  32  last popped word; held until the next successful pop.

Behaviour:
- Reset (async, reset = 0):
  - state = IDLE; op_ready = 1.
  - wr_sp, mem_req, mem_we, done, fault = 0.
  - mem_addr, mem_wdata, wr_sp_data, pop_data, fault_code, timeout counter = 0.
- Reset asserted mid-operation: the op is abandoned immediately. No wr_sp, no done. Memory sees mem_req drop.
- States: IDLE, MEM, WB, FLT.
- IDLE:
  - op_ready = 1.
  - An op is accepted on the cycle op_valid = 1. op_push, push_data and sp_in are captured that cycle.
- Checks at accept, evaluated in priority order:
  - 1. sp_in[1:0] != 0, or sp_in outside [STACK_LIMIT, STACK_BASE] -> code 3.
  - 2. Push with sp_in == STACK_LIMIT (full) -> code 1.
  - 3. Pop with sp_in == STACK_BASE (empty) -> code 2.
  - Any check failing -> FLT. Otherwise -> MEM.
- Address rule (full-descending stack):
  - Push: mem_addr = sp_in - 4; new SP = sp_in - 4.
  - Pop: mem_addr = sp_in; new SP = sp_in + 4.
  - All arithmetic is 32-bit, computed at accept, registered.
- MEM:
  - mem_req = 1, with mem_we/mem_addr/mem_wdata stable for the whole state.
  - The timeout counter increments each cycle mem_ack = 0.
  - mem_ack = 1 -> WB. On a pop, pop_data <= mem_rdata in the same edge.
  - Counter reaching TIMEOUT - 1 without ack -> FLT with code 0; mem_req drops.
  - If ack and timeout coincide, ack wins.
- WB:
  - Single cycle: wr_sp = 1, wr_sp_data = new SP, done = 1, fault = 0.
  - Next state IDLE.
- FLT:
  - Single cycle: done = 1, fault = 1, fault_code valid.
  - No wr_sp; pop_data unchanged. Next state IDLE.
- op_ready = 0 in MEM, WB and FLT. op_valid is ignored while not ready; the requester holds it.
- Latency, best case (ack in the first MEM cycle): accept at cycle 0, mem_req at cycle 1, wr_sp/done at cycle 2, next accept at cycle 3.
- A fault is reported 1 cycle after accept.
- mem_ack outside MEM is ignored.
- sp_in is not re-sampled after accept. Control guarantees no other SP writer while op_ready = 0.

Decomposition:
- Shared package scc_pkg holds:
  - state encoding (IDLE = 0, MEM = 1, WB = 2, FLT = 3);
  - fault codes FC_TIMEOUT / FC_OVF / FC_UNF / FC_ALIGN;
  - SP register index 4;
  - word size 4.
- No sub-module is needed. The timeout counter is inline.

Test Plan:
- Push, sp_in = 0x1000, push_data = 0xDEADBEEF, ack on first MEM cycle:
  - mem_req with we = 1, addr = 0x0FFC, wdata = 0xDEADBEEF;
  - next cycle wr_sp = 1, wr_sp_data = 0x0FFC, done = 1, fault = 0.
- Pop, sp_in = 0x0FFC, ack after 3 cycles with rdata = 0x12345678:
  - mem_req held 4 cycles at addr = 0x0FFC, we = 0;
  - then wr_sp_data = 0x1000, pop_data = 0x12345678, done.
- Boundaries:
  - Pop at sp_in = 0x1000 -> done + fault, code 2, no mem_req, no wr_sp.
  - Push at sp_in = 0x0800 -> code 1.
  - sp_in = 0x0FFE -> code 3.
- No ack for 16 cycles:
  - mem_req drops after cycle 16, then done + fault with code 0;
  - pop_data unchanged; op_ready = 1 the following cycle.
- Drop reset to 0 during MEM:
  - all outputs return to reset values asynchronously; no wr_sp, no done.
  - After release, a push of 0xA5A5A5A5 at sp_in = 0x1000 completes normally.
- op_valid held high continuously over back-to-back pushes from 0x1000:
  - ops accepted only when op_ready = 1, every 3 cycles;
  - SP sequence 0x0FFC, 0x0FF8, 0x0FF4.
